traffic_controller: RTL and testbench

- Two-way traffic-light controller: a Moore FSM alternates right-of-way between signal 1 and signal 2.
- Each approach cycles GREEN -> YELLOW -> RED.
- An all-red clearance interval separates every handover.
- Sits at the top of the intersection design and drives the lamp drivers directly with one-hot light codes.

---
 rtl/traffic_controller.sv | 112 +++++++++++
 tb/tb_traffic_controller.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/traffic_controller.sv
// Two-way intersection light controller.
// Moore FSM with dwell counter and registered one-hot lamp codes.
module traffic_controller #(
  parameter int unsigned GREEN_TIME  = 5,
  parameter int unsigned YELLOW_TIME = 2,
  parameter int unsigned ALLRED_TIME = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] signal1_light,
  output logic [2:0] signal2_light
);

  if (GREEN_TIME  < 1 || GREEN_TIME  > 255 ||
      YELLOW_TIME < 1 || YELLOW_TIME > 255 ||
      ALLRED_TIME < 1 || ALLRED_TIME > 255) begin : g_param_check
    $error("traffic_controller: phase times must be 1..255");
  end

  typedef enum logic [2:0] {
    S1_GREEN  = 3'd0,
    S1_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    S2_GREEN  = 3'd3,
    S2_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } state_e;

  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] RED = 3'b100;

  localparam logic [7:0] G_LAST = 8'(GREEN_TIME - 1);
  localparam logic [7:0] Y_LAST = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] A_LAST = 8'(ALLRED_TIME - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] s1_q, s1_d;
  logic [2:0] s2_q, s2_d;
  logic [7:0] last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ALLRED_B;
      cnt_q   <= 8'd0;
      s1_q    <= RED;
      s2_q    <= RED;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end

  always_comb begin
    last    = 8'd0;
    state_d = ALLRED_B;
    cnt_d   = 8'd0;
    case (state_q)
      S1_GREEN, S2_GREEN:   last = G_LAST;
      S1_YELLOW, S2_YELLOW: last = Y_LAST;
      ALLRED_A, ALLRED_B:   last = A_LAST;
      default:              last = 8'd0;
    endcase
    // Undefined encodings fall through to ALLRED_B with a fresh count.
    case (state_q)
      S1_GREEN, S1_YELLOW, ALLRED_A,
      S2_GREEN, S2_YELLOW, ALLRED_B: begin
        if (cnt_q == last) begin
          cnt_d = 8'd0;
          case (state_q)
            S1_GREEN:  state_d = S1_YELLOW;
            S1_YELLOW: state_d = ALLRED_A;
            ALLRED_A:  state_d = S2_GREEN;
            S2_GREEN:  state_d = S2_YELLOW;
            S2_YELLOW: state_d = ALLRED_B;
            default:   state_d = S1_GREEN;
          endcase
        end else begin
          state_d = state_q;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ALLRED_B;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Decode from the next state so lamps register on the same edge.
  always_comb begin
    s1_d = RED;
    s2_d = RED;
    case (state_d)
      S1_GREEN:  s1_d = GRN;
      S1_YELLOW: s1_d = YEL;
      S2_GREEN:  s2_d = GRN;
      S2_YELLOW: s2_d = YEL;
      default: begin
        s1_d = RED;
        s2_d = RED;
      end
    endcase
  end

  assign signal1_light = s1_q;
  assign signal2_light = s2_q;

endmodule

// File: tb/tb_traffic_controller.sv
// Directed bench for traffic_controller.
// Default and overridden timing instances, reset corner cases.
module tb_traffic_controller;

  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] RED = 3'b100;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst2;
  logic [2:0] s1, s2;
  logic [2:0] t1, t2;

  int ntests = 0;
  int nfail  = 0;
  int n;

  always #5 clk = ~clk;

  traffic_controller u_dut (
    .clk           (clk),
    .rst           (rst),
    .signal1_light (s1),
    .signal2_light (s2)
  );

  traffic_controller #(
    .GREEN_TIME  (3),
    .YELLOW_TIME (1),
    .ALLRED_TIME (2)
  ) u_dut2 (
    .clk           (clk),
    .rst           (rst2),
    .signal1_light (t1),
    .signal2_light (t2)
  );

  task automatic check(input string tag,
                       input logic [5:0] got,
                       input logic [5:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got=%b exp=%b", tag, $time, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // n = rising edges since reset release; n=0 is the start of ALLRED_B.
  function automatic logic [5:0] model(int g, int y, int a, int e);
    int per, p, half;
    logic [2:0] act;
    half = g + y + a;
    per  = 2 * half;
    p    = (2 * g + 2 * y + a + e) % per;
    if (p % half < g)          act = GRN;
    else if (p % half < g + y) act = YEL;
    else                       act = RED;
    if (p < half) return {act, RED};
    return {RED, act};
  endfunction

  function automatic logic safe(logic [2:0] a, logic [2:0] b);
    logic la, lb;
    la = (a == GRN) || (a == YEL) || (a == RED);
    lb = (b == GRN) || (b == YEL) || (b == RED);
    return la && lb && (a == RED || b == RED);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    rst2 = 1'b1;
    #1;
    rst  = 1'b0;
    rst2 = 1'b0;
    #1;
    check("rst_async", {s1, s2}, {RED, RED});
    check("rst2_async", {t1, t2}, {RED, RED});
    repeat (2) begin
      tick();
      check("rst_hold", {s1, s2}, {RED, RED});
    end

    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_pre", {s1, s2}, {RED, RED});
    n = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      n++;
      check("seq", {s1, s2}, model(5, 2, 1, n));
      check("safe", 6'(safe(s1, s2)), 6'd1);
    end
    check("idle2", {t1, t2}, {RED, RED});

    while ((15 + n) % 16 != 10) begin
      tick();
      n++;
      check("seq_wait", {s1, s2}, model(5, 2, 1, n));
    end
    check("pre_midrst", {s1, s2}, {RED, GRN});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_async", {s1, s2}, {RED, RED});
    repeat (2) begin
      tick();
      check("midrst_hold", {s1, s2}, {RED, RED});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrel_pre", {s1, s2}, {RED, RED});
    tick();
    check("restart_g1", {s1, s2}, {GRN, RED});

    @(negedge clk);
    rst2 = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n++;
      check("ovr_seq", {t1, t2}, model(3, 1, 2, n));
      check("ovr_safe", 6'(safe(t1, t2)), 6'd1);
    end

    @(negedge clk);
    rst2 = 1'b0;
    #1;
    check("b2b_async", {t1, t2}, {RED, RED});
    repeat (3) begin
      tick();
      check("b2b_low", {t1, t2}, {RED, RED});
      @(negedge clk);
      rst2 = 1'b1;
      tick();
      check("b2b_gap", {t1, t2}, {RED, RED});
      @(negedge clk);
      rst2 = 1'b0;
      #1;
      check("b2b_pulse", {t1, t2}, {RED, RED});
    end
    @(negedge clk);
    rst2 = 1'b1;
    tick();
    check("b2b_ar1", {t1, t2}, {RED, RED});
    tick();
    check("b2b_g1", {t1, t2}, {GRN, RED});

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
